// File: rtl/aes_ctr_sequencer.sv
// CTR-mode sequencer around a free-running pipelined aes_128 core: issues counter
// blocks, delays the payload alongside the core, XORs the keystream and buffers results.
module aes_ctr_sequencer #(
  parameter int PIPE_LAT   = 20,
  parameter int FIFO_DEPTH = 32
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_start,
  input  logic [63:0]  i_nonce,
  input  logic [63:0]  i_ctr_init,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [127:0] i_in_data,
  input  logic         i_in_last,
  output logic [127:0] o_core_state,
  input  logic [127:0] i_core_out,
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [127:0] o_out_data,
  output logic         o_out_last,
  output logic         o_busy,
  output logic         o_done,
  output logic         o_ctr_wrap
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  logic [63:0]        r_nonce;
  logic [63:0]        r_ctr;
  logic               r_wrap;

  logic [PIPE_LAT-1:0] r_tag;
  logic [127:0]       r_dly_data [PIPE_LAT];
  logic               r_dly_last [PIPE_LAT];

  logic [128:0]       r_mem [FIFO_DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_count;
  logic [CW-1:0]      r_inflight;

  logic               w_accept;
  logic               w_fifo_wr;
  logic               w_fifo_rd;
  logic               w_load;
  logic [CW:0]        w_occupancy;

  // Blocks in the core plus blocks buffered never exceed the FIFO, so an exit always has room.
  assign w_occupancy  = {1'b0, r_inflight} + {1'b0, r_count};
  assign o_in_ready   = (r_state == S_RUN) && (w_occupancy < (CW+1)'(FIFO_DEPTH));
  assign w_accept     = i_in_valid && o_in_ready;
  assign w_load       = (r_state == S_IDLE) && i_start;
  assign w_fifo_wr    = r_tag[PIPE_LAT-1];
  assign o_out_valid  = (r_count != '0);
  assign w_fifo_rd    = o_out_valid && i_out_ready;

  assign o_core_state = {r_nonce, r_ctr};
  assign o_out_data   = o_out_valid ? r_mem[r_rd_ptr][127:0] : '0;
  assign o_out_last   = o_out_valid && r_mem[r_rd_ptr][128];
  assign o_busy       = (r_state != S_IDLE);
  assign o_ctr_wrap   = r_wrap;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if (w_accept && i_in_last) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        // Final beat leaves the FIFO this cycle and nothing remains in the core.
        if ((r_inflight == '0) && (r_count == CW'(1)) && i_out_ready) begin
          w_state_nxt = S_IDLE;
          o_done      = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_nonce <= '0;
      r_ctr   <= '0;
      r_wrap  <= 1'b0;
    end else if (w_load) begin
      r_nonce <= i_nonce;
      r_ctr   <= i_ctr_init;
      r_wrap  <= 1'b0;
    end else if (w_accept) begin
      r_ctr <= r_ctr + 64'd1;
      if (r_ctr == '1) r_wrap <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_tag <= '0;
    end else begin
      r_tag[0] <= w_accept;
      for (int i = 1; i < PIPE_LAT; i++) begin
        r_tag[i] <= r_tag[i-1];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    r_dly_data[0] <= i_in_data;
    r_dly_last[0] <= i_in_last;
    for (int i = 1; i < PIPE_LAT; i++) begin
      r_dly_data[i] <= r_dly_data[i-1];
      r_dly_last[i] <= r_dly_last[i-1];
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_fifo_wr) begin
      r_mem[r_wr_ptr] <= {r_dly_last[PIPE_LAT-1], r_dly_data[PIPE_LAT-1] ^ i_core_out};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_inflight <= '0;
    end else begin
      if (w_fifo_wr) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_fifo_rd) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_fifo_wr, w_fifo_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      case ({w_accept, w_fifo_wr})
        2'b10:   r_inflight <= r_inflight + CW'(1);
        2'b01:   r_inflight <= r_inflight - CW'(1);
        default: r_inflight <= r_inflight;
      endcase
    end
  end

endmodule
